// File: rtl/snake_frame_builder.sv
// Snake frame builder: snapshots the packed snake and food, rasterises them into a
// double-buffered 16x16 occupancy bitmap and flags head self-collision / head-on-food.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for write_snake; snapshot taken on the leaving edge
//   CLEAR | zero one back-buffer row per cycle (16 cycles)
//   PLOT  | set one segment cell per cycle, accumulate head/body hits
//   FOOD  | compare head with latched food
//   SWAP  | flip front/back, publish food position, hits and frame_done
module snake_frame_builder #(
   parameter int GRID    = 16,
   parameter int MAX_SEG = 10,
   parameter int SEG_W   = 8
) (
   input  logic                       slw_clk,
   input  logic                       reset,
   input  logic [MAX_SEG*SEG_W-1:0]   snake,
   input  logic [10:0]                index,
   input  logic                       write_snake,
   input  logic [$clog2(GRID)-1:0]    xfood,
   input  logic [$clog2(GRID)-1:0]    yfood,
   input  logic [$clog2(GRID)-1:0]    rd_row,
   output logic [GRID-1:0]            rd_body,
   output logic [GRID-1:0]            rd_food,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       self_hit,
   output logic                       food_hit,
   output logic                       len_err
);

   localparam int CW = $clog2(GRID);
   localparam int NW = $clog2(MAX_SEG + 1);
   localparam int SH = $clog2(SEG_W);
   localparam logic [NW-1:0] ONE_N = NW'(1);
   localparam logic [NW-1:0] MAX_N = NW'(MAX_SEG);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      PLOT  = 3'd2,
      FOOD  = 3'd3,
      SWAP  = 3'd4
   } state_t;

   state_t state;
   state_t state_nx;

   logic [1:0][GRID-1:0][GRID-1:0]    bm;
   logic                              front_sel;
   logic                              back_sel;

   logic [MAX_SEG-1:0][SEG_W-1:0]     seg_q;
   logic [NW-1:0]                     nseg_q;
   logic [CW-1:0]                     fx_q;
   logic [CW-1:0]                     fy_q;
   logic [CW-1:0]                     front_fx;
   logic [CW-1:0]                     front_fy;
   logic [CW-1:0]                     row_cnt;
   logic [NW-1:0]                     seg_cnt;
   logic                              hit_acc;
   logic                              food_acc;

   logic [10:0]                       idx_inc;
   logic [10:0]                       nseg_raw;
   logic                              nseg_over;
   logic [NW-1:0]                     nseg_in;
   logic [SEG_W-1:0]                  cur_seg;
   logic [SEG_W-1:0]                  head_seg;
   logic                              last_seg;

   // Segment count uses 11-bit wrap: index 2047 yields zero segments.
   assign idx_inc   = index + 11'd1;
   assign nseg_raw  = idx_inc >> SH;
   assign nseg_over = nseg_raw > 11'(MAX_SEG);
   assign nseg_in   = nseg_over ? MAX_N : nseg_raw[NW-1:0];

   assign cur_seg   = seg_q[seg_cnt];
   assign head_seg  = (nseg_q == '0) ? '0 : seg_q[nseg_q - ONE_N];
   assign last_seg  = (seg_cnt == nseg_q - ONE_N);

   assign back_sel  = ~front_sel;
   assign busy      = (state != IDLE);

   assign rd_body   = bm[front_sel][rd_row];
   assign rd_food   = (rd_row == front_fy) ? (GRID'(1) << front_fx) : '0;

   always_ff @(posedge slw_clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (write_snake) state_nx = CLEAR;
         CLEAR:   if (row_cnt == '0) state_nx = (nseg_q == '0) ? FOOD : PLOT;
         PLOT:    if (last_seg) state_nx = FOOD;
         FOOD:    state_nx = SWAP;
         SWAP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge slw_clk) begin
      if (reset) begin
         bm         <= '0;
         front_sel  <= 1'b0;
         seg_q      <= '0;
         nseg_q     <= '0;
         fx_q       <= '0;
         fy_q       <= '0;
         front_fx   <= '0;
         front_fy   <= '0;
         row_cnt    <= '0;
         seg_cnt    <= '0;
         hit_acc    <= 1'b0;
         food_acc   <= 1'b0;
         frame_done <= 1'b0;
         self_hit   <= 1'b0;
         food_hit   <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               row_cnt <= CW'(GRID - 1);
               seg_cnt <= '0;
               if (write_snake) begin
                  seg_q    <= snake;
                  nseg_q   <= nseg_in;
                  fx_q     <= xfood;
                  fy_q     <= yfood;
                  hit_acc  <= 1'b0;
                  food_acc <= 1'b0;
                  if (nseg_over) len_err <= 1'b1;
               end
            end
            CLEAR: begin
               bm[back_sel][row_cnt] <= '0;
               row_cnt               <= row_cnt - CW'(1);
            end
            PLOT: begin
               bm[back_sel][cur_seg[2*CW-1:CW]][cur_seg[CW-1:0]] <= 1'b1;
               // The head itself is the last segment plotted and is not compared.
               if (!last_seg && (cur_seg == head_seg)) hit_acc <= 1'b1;
               seg_cnt <= seg_cnt + ONE_N;
            end
            FOOD: begin
               food_acc <= (nseg_q != '0) && (head_seg[2*CW-1:0] == {fy_q, fx_q});
            end
            SWAP: begin
               front_sel  <= back_sel;
               front_fx   <= fx_q;
               front_fy   <= fy_q;
               self_hit   <= hit_acc;
               food_hit   <= food_acc;
               frame_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
